id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Registered, parametrised instruction-decode stage for the LoongArch32 scalar pipeline, sitting between the fetch output and the EXE stage.
- Decodes the integer ALU subset (LU12I.W, 3R logic/arith/shift, 2RI12, shift-immediate) and reads the register file.
- Resolves operands through an N-port forwarding network and interlocks on load-use hazards.
- Holds the result in an output pipeline register under a valid/ready handshake with flush support.

## Interface
- DATA_WIDTH, 32, register/operand width
- ADDR_WIDTH, 32, PC width
- FWD_PORTS, 2, forwarding sources; port 0 is youngest and has highest priority
- CNT_WIDTH, 16, stall counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  instruction accepted this cycle
- pc_i  in  ADDR_WIDTH  instruction PC
- inst_i  in  32  instruction word
- reg1_addr_o, reg2_addr_o  out  5  regfile read addresses (combinational, rj / rk)
- reg1_data_i, reg2_data_i  in  DATA_WIDTH  regfile read data, same cycle
- fwd_valid_i  in  FWD_PORTS  producer will write fwd_waddr_i
- fwd_waddr_i  in  5*FWD_PORTS  producer destination
- fwd_wdata_i  in  DATA_WIDTH*FWD_PORTS  producer data
- fwd_data_ready_i  in  FWD_PORTS  0 = data not yet available (load in flight)
- ex_valid_o  out  1  output register holds an instruction
- ex_ready_i  in  1  EXE consumes this cycle
- aluop_o, alusel_o  out  8 / 3  operation and result-select codes
- reg1_o, reg2_o  out  DATA_WIDTH  resolved operands
- reg_waddr_o  out  5  destination rd
- wreg_o  out  1  write-back enable
- inst_valid_o  out  1  instruction legal
- inst_pc_o  out  ADDR_WIDTH  PC of registered instruction
- stall_cnt_o  out  CNT_WIDTH  saturating count of load-use stall cycles

## Operation

**Decode.** Combinational, on `inst_i`.
- Immediates:
  - ADDI.W, SLTI, SLTUI sign-extend si12.
  - ANDI, ORI, XORI zero-extend ui12.
  - Shift-immediates zero-extend ui5.
  - LU12I.W uses `{si20,12'b0}`.
- Source operands:
  - `reg1_o` = rj value if read, else 0.
  - `reg2_o` = rk value if read, else the immediate.
  - LU12I.W reads no register.
- Illegal encoding: `inst_valid_o`=0, `wreg_o`=0, `aluop_o`/`alusel_o`=NOP. The instruction still advances.

**Operand resolution**, per read source:
1. Register 0 yields 0.
2. Otherwise, the lowest-index forwarding port with `fwd_valid_i` and a matching address supplies `fwd_wdata_i`.
3. Otherwise the value comes from the register file.

**Hazard.** `hazard` = `if_valid_i` AND some read source whose selected forwarding port has `fwd_data_ready_i`=0. Register 0 never hazards.

**Handshake.**
- `advance` = !`ex_valid_o` | `ex_ready_i`.
- `if_ready_o` = `flush_i` | (`advance` & !`hazard`).
- Accept when `if_valid_i` & `if_ready_o` & !`flush_i`: load all outputs, `ex_valid_o`←1.
- When `advance` holds and nothing is accepted, `ex_valid_o`←0 (bubble).
- When !`advance`, all output registers hold.

**Flush.** Has priority over everything: `ex_valid_o`←0 next edge and the input instruction is dropped.

**Stall counter.** `stall_cnt_o` increments on each cycle with `hazard` & `advance` & !`flush_i`, and saturates at all-ones.

## Timing
- Decode-to-output latency is 1 cycle; throughput is 1 instruction/cycle without hazards.
- Reset values (async assert):
  - `ex_valid_o`=0, `wreg_o`=0, `inst_valid_o`=0.
  - `aluop_o`=NOP, `alusel_o`=NOP.
  - `reg1_o`=`reg2_o`=0, `reg_waddr_o`=0, `inst_pc_o`=0, `stall_cnt_o`=0.
- Reset mid-operation discards the registered instruction.
- Hazard resolves in the same cycle `fwd_data_ready_i` rises; the instruction is accepted at that edge with the forwarded data.
- With `ex_ready_i`=0 and `ex_valid_o`=1, outputs are bit-stable and `if_ready_o`=0 (unless `flush_i`).
- Flush and a hazard in the same cycle: flush wins and the counter does not increment.

## Structure
- Package `id_pkg`: aluop/alusel codes, opcode field constants (LU12I.W 7-bit; 2RI12 10-bit; 3R and shift-immediate 17-bit), and a `decode_t` struct.
- Sub-module `id_decoder`: purely combinational, `inst_i` → `decode_t` (aluop, alusel, read enables, imm, waddr, wreg, legal).
- Top level holds the forwarding mux, hazard logic, output register and counter.

## Test plan
- ORI r1,r0,0x123 (`0x03848C01`), ready=1: next cycle `ex_valid_o`=1, `reg1_o`=0, `reg2_o`=0x00000123, `reg_waddr_o`=1, `wreg_o`=1.
- ADDI.W r2,r1,-1 (`0x02BFFC22`) with regfile r1=5: `reg1_o`=5, `reg2_o`=0xFFFFFFFF.
- Forwarding priority: ADD.W r3,r1,r2 (`0x00100823`); both ports valid with waddr 1, data 0xAAAA/0xBBBB → `reg1_o`=0xAAAA.
- Load-use on the same ADD.W:
  - Port0 waddr=1, `fwd_data_ready_i`=0 for 3 cycles → `if_ready_o`=0, three bubbles, `stall_cnt_o`=3.
  - Ready rises with data 0x55 → accepted, `reg1_o`=0x55.
- Backpressure, flush and reset:
  - `ex_ready_i`=0 for 2 cycles → outputs stable.
  - `flush_i` pulse → `ex_valid_o`=0 next cycle.
  - `rst` asserted mid-stall → all reset values.
- Illegal word `0xFFFFFFFF` → `ex_valid_o`=1, `inst_valid_o`=0, `wreg_o`=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the LoongArch32 decode stage: ALU codes, opcode fields
// and the decoder result record.
package id_pkg;

    localparam logic [7:0] AluopNop  = 8'h00;
    localparam logic [7:0] AluopAnd  = 8'h01;
    localparam logic [7:0] AluopOr   = 8'h02;
    localparam logic [7:0] AluopXor  = 8'h03;
    localparam logic [7:0] AluopNor  = 8'h04;
    localparam logic [7:0] AluopAdd  = 8'h10;
    localparam logic [7:0] AluopSub  = 8'h11;
    localparam logic [7:0] AluopSlt  = 8'h12;
    localparam logic [7:0] AluopSltu = 8'h13;
    localparam logic [7:0] AluopSll  = 8'h20;
    localparam logic [7:0] AluopSrl  = 8'h21;
    localparam logic [7:0] AluopSra  = 8'h22;

    localparam logic [2:0] AluselNop   = 3'd0;
    localparam logic [2:0] AluselLogic = 3'd1;
    localparam logic [2:0] AluselShift = 3'd2;
    localparam logic [2:0] AluselArith = 3'd3;

    localparam logic [6:0] Op7Lu12iW = 7'b0001010;

    localparam logic [9:0] Op10Slti  = 10'h008;
    localparam logic [9:0] Op10Sltui = 10'h009;
    localparam logic [9:0] Op10AddiW = 10'h00a;
    localparam logic [9:0] Op10Andi  = 10'h00d;
    localparam logic [9:0] Op10Ori   = 10'h00e;
    localparam logic [9:0] Op10Xori  = 10'h00f;

    localparam logic [16:0] Op17AddW  = 17'h00020;
    localparam logic [16:0] Op17SubW  = 17'h00022;
    localparam logic [16:0] Op17Slt   = 17'h00024;
    localparam logic [16:0] Op17Sltu  = 17'h00025;
    localparam logic [16:0] Op17Nor   = 17'h00028;
    localparam logic [16:0] Op17And   = 17'h00029;
    localparam logic [16:0] Op17Or    = 17'h0002a;
    localparam logic [16:0] Op17Xor   = 17'h0002b;
    localparam logic [16:0] Op17SllW  = 17'h0002e;
    localparam logic [16:0] Op17SrlW  = 17'h0002f;
    localparam logic [16:0] Op17SraW  = 17'h00030;
    localparam logic [16:0] Op17SlliW = 17'h00081;
    localparam logic [16:0] Op17SrliW = 17'h00089;
    localparam logic [16:0] Op17SraiW = 17'h00091;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        re1;
        logic        re2;
        logic [31:0] imm;
        logic [4:0]  waddr;
        logic        wreg;
        logic        legal;
    } decode_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational decoder for the LoongArch32 integer ALU subset.
module id_decoder
    import id_pkg::*;
(
    input  logic [31:0] inst_i,
    output decode_t     dec_o
);

    logic [31:0] si12, ui12, ui5;

    assign si12 = {{20{inst_i[21]}}, inst_i[21:10]};
    assign ui12 = {20'b0, inst_i[21:10]};
    assign ui5  = {27'b0, inst_i[14:10]};

    always_comb begin
        dec_o       = '0;
        dec_o.waddr = inst_i[4:0];
        if (inst_i[31:25] == Op7Lu12iW) begin
            dec_o.aluop  = AluopOr;
            dec_o.alusel = AluselLogic;
            dec_o.imm    = {inst_i[24:5], 12'b0};
            dec_o.legal  = 1'b1;
        end else begin
            // 2RI12: every legal form reads rj and uses an immediate for operand 2
            dec_o.legal = 1'b1;
            dec_o.re1   = 1'b1;
            unique case (inst_i[31:22])
                Op10Slti:  begin dec_o.aluop = AluopSlt;  dec_o.alusel = AluselArith; dec_o.imm = si12; end
                Op10Sltui: begin dec_o.aluop = AluopSltu; dec_o.alusel = AluselArith; dec_o.imm = si12; end
                Op10AddiW: begin dec_o.aluop = AluopAdd;  dec_o.alusel = AluselArith; dec_o.imm = si12; end
                Op10Andi:  begin dec_o.aluop = AluopAnd;  dec_o.alusel = AluselLogic; dec_o.imm = ui12; end
                Op10Ori:   begin dec_o.aluop = AluopOr;   dec_o.alusel = AluselLogic; dec_o.imm = ui12; end
                Op10Xori:  begin dec_o.aluop = AluopXor;  dec_o.alusel = AluselLogic; dec_o.imm = ui12; end
                default: begin
                    dec_o.re2 = 1'b1;
                    unique case (inst_i[31:15])
                        Op17AddW:  begin dec_o.aluop = AluopAdd;  dec_o.alusel = AluselArith; end
                        Op17SubW:  begin dec_o.aluop = AluopSub;  dec_o.alusel = AluselArith; end
                        Op17Slt:   begin dec_o.aluop = AluopSlt;  dec_o.alusel = AluselArith; end
                        Op17Sltu:  begin dec_o.aluop = AluopSltu; dec_o.alusel = AluselArith; end
                        Op17Nor:   begin dec_o.aluop = AluopNor;  dec_o.alusel = AluselLogic; end
                        Op17And:   begin dec_o.aluop = AluopAnd;  dec_o.alusel = AluselLogic; end
                        Op17Or:    begin dec_o.aluop = AluopOr;   dec_o.alusel = AluselLogic; end
                        Op17Xor:   begin dec_o.aluop = AluopXor;  dec_o.alusel = AluselLogic; end
                        Op17SllW:  begin dec_o.aluop = AluopSll;  dec_o.alusel = AluselShift; end
                        Op17SrlW:  begin dec_o.aluop = AluopSrl;  dec_o.alusel = AluselShift; end
                        Op17SraW:  begin dec_o.aluop = AluopSra;  dec_o.alusel = AluselShift; end
                        Op17SlliW: begin dec_o.aluop = AluopSll;  dec_o.alusel = AluselShift; dec_o.re2 = 1'b0; dec_o.imm = ui5; end
                        Op17SrliW: begin dec_o.aluop = AluopSrl;  dec_o.alusel = AluselShift; dec_o.re2 = 1'b0; dec_o.imm = ui5; end
                        Op17SraiW: begin dec_o.aluop = AluopSra;  dec_o.alusel = AluselShift; dec_o.re2 = 1'b0; dec_o.imm = ui5; end
                        default:   dec_o = '0;
                    endcase
                end
            endcase
            dec_o.waddr = inst_i[4:0];
            dec_o.wreg  = dec_o.legal;
        end
        if (inst_i[31:25] == Op7Lu12iW) dec_o.wreg = 1'b1;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: operand forwarding, load-use interlock and an output
// pipeline register under a valid/ready handshake.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FWD_PORTS  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            if_valid_i,
    output logic                            if_ready_o,
    input  logic [ADDR_WIDTH-1:0]           pc_i,
    input  logic [31:0]                     inst_i,
    output logic [4:0]                      reg1_addr_o,
    output logic [4:0]                      reg2_addr_o,
    input  logic [DATA_WIDTH-1:0]           reg1_data_i,
    input  logic [DATA_WIDTH-1:0]           reg2_data_i,
    input  logic [FWD_PORTS-1:0]            fwd_valid_i,
    input  logic [5*FWD_PORTS-1:0]          fwd_waddr_i,
    input  logic [DATA_WIDTH*FWD_PORTS-1:0] fwd_wdata_i,
    input  logic [FWD_PORTS-1:0]            fwd_data_ready_i,
    output logic                            ex_valid_o,
    input  logic                            ex_ready_i,
    output logic [7:0]                      aluop_o,
    output logic [2:0]                      alusel_o,
    output logic [DATA_WIDTH-1:0]           reg1_o,
    output logic [DATA_WIDTH-1:0]           reg2_o,
    output logic [4:0]                      reg_waddr_o,
    output logic                            wreg_o,
    output logic                            inst_valid_o,
    output logic [ADDR_WIDTH-1:0]           inst_pc_o,
    output logic [CNT_WIDTH-1:0]            stall_cnt_o
);

    decode_t dec;

    id_decoder u_decoder (
        .inst_i (inst_i),
        .dec_o  (dec)
    );

    assign reg1_addr_o = inst_i[9:5];
    assign reg2_addr_o = inst_i[14:10];

    logic [DATA_WIDTH-1:0] src1, src2, op1, op2;
    logic                  rdy1, rdy2, hazard, advance, accept;

    // Scan from the oldest port down so the youngest matching producer wins.
    always_comb begin
        src1 = reg1_data_i;
        src2 = reg2_data_i;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        for (int p = FWD_PORTS - 1; p >= 0; p--) begin
            if (fwd_valid_i[p] && fwd_waddr_i[p*5 +: 5] == reg1_addr_o) begin
                src1 = fwd_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                rdy1 = fwd_data_ready_i[p];
            end
            if (fwd_valid_i[p] && fwd_waddr_i[p*5 +: 5] == reg2_addr_o) begin
                src2 = fwd_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                rdy2 = fwd_data_ready_i[p];
            end
        end
        if (reg1_addr_o == 5'd0) begin
            src1 = '0;
            rdy1 = 1'b1;
        end
        if (reg2_addr_o == 5'd0) begin
            src2 = '0;
            rdy2 = 1'b1;
        end
    end

    assign op1        = dec.re1 ? src1 : '0;
    assign op2        = dec.re2 ? src2 : DATA_WIDTH'(dec.imm);
    assign hazard     = if_valid_i & ((dec.re1 & ~rdy1) | (dec.re2 & ~rdy2));
    assign advance    = ~ex_valid_o | ex_ready_i;
    assign if_ready_o = flush_i | (advance & ~hazard);
    assign accept     = if_valid_i & if_ready_o & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o   <= 1'b0;
            aluop_o      <= AluopNop;
            alusel_o     <= AluselNop;
            reg1_o       <= '0;
            reg2_o       <= '0;
            reg_waddr_o  <= '0;
            wreg_o       <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_pc_o    <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (accept) begin
            ex_valid_o   <= 1'b1;
            aluop_o      <= dec.aluop;
            alusel_o     <= dec.alusel;
            reg1_o       <= op1;
            reg2_o       <= op2;
            reg_waddr_o  <= dec.waddr;
            wreg_o       <= dec.wreg;
            inst_valid_o <= dec.legal;
            inst_pc_o    <= pc_i;
        end else if (advance) begin
            ex_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (hazard && advance && !flush_i && stall_cnt_o != {CNT_WIDTH{1'b1}}) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by random
// traffic compared against a transaction-level reference model.
module tb_id_stage_pipe;
    import id_pkg::*;

    localparam int NP = 2;
    localparam int CW = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic flush, if_valid, if_ready, ex_valid, ex_ready, wreg, ivalid;
    logic [31:0] pc, inst, r1d, r2d, reg1, reg2, ipc;
    logic [4:0] r1a, r2a, waddr;
    logic [NP-1:0] fvalid, frdy;
    logic [5*NP-1:0] fwaddr;
    logic [32*NP-1:0] fwdata;
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic [CW-1:0] scnt;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FWD_PORTS(NP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .pc_i(pc), .inst_i(inst), .reg1_addr_o(r1a), .reg2_addr_o(r2a),
        .reg1_data_i(r1d), .reg2_data_i(r2d), .fwd_valid_i(fvalid), .fwd_waddr_i(fwaddr),
        .fwd_wdata_i(fwdata), .fwd_data_ready_i(frdy), .ex_valid_o(ex_valid),
        .ex_ready_i(ex_ready), .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1),
        .reg2_o(reg2), .reg_waddr_o(waddr), .wreg_o(wreg), .inst_valid_o(ivalid),
        .inst_pc_o(ipc), .stall_cnt_o(scnt)
    );

    int n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction table: kind 0=3R, 1=si12, 2=ui12, 3=ui5 shift, 4=LU12I.W
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [7:0]  aop;
        logic [2:0]  asel;
        int          kind;
    } ent_t;
    ent_t tbl[$];

    function automatic void add(input logic [31:0] mk, input logic [31:0] mt,
                                input logic [7:0] a, input logic [2:0] s, input int k);
        ent_t e;
        e.mask = mk; e.match = mt; e.aop = a; e.asel = s; e.kind = k;
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        add(32'hfe00_0000, 32'h1400_0000, AluopOr,   AluselLogic, 4);
        add(32'hffc0_0000, 32'h0200_0000, AluopSlt,  AluselArith, 1);
        add(32'hffc0_0000, 32'h0240_0000, AluopSltu, AluselArith, 1);
        add(32'hffc0_0000, 32'h0280_0000, AluopAdd,  AluselArith, 1);
        add(32'hffc0_0000, 32'h0340_0000, AluopAnd,  AluselLogic, 2);
        add(32'hffc0_0000, 32'h0380_0000, AluopOr,   AluselLogic, 2);
        add(32'hffc0_0000, 32'h03c0_0000, AluopXor,  AluselLogic, 2);
        add(32'hffff_8000, 32'h0010_0000, AluopAdd,  AluselArith, 0);
        add(32'hffff_8000, 32'h0011_0000, AluopSub,  AluselArith, 0);
        add(32'hffff_8000, 32'h0012_0000, AluopSlt,  AluselArith, 0);
        add(32'hffff_8000, 32'h0012_8000, AluopSltu, AluselArith, 0);
        add(32'hffff_8000, 32'h0014_0000, AluopNor,  AluselLogic, 0);
        add(32'hffff_8000, 32'h0014_8000, AluopAnd,  AluselLogic, 0);
        add(32'hffff_8000, 32'h0015_0000, AluopOr,   AluselLogic, 0);
        add(32'hffff_8000, 32'h0015_8000, AluopXor,  AluselLogic, 0);
        add(32'hffff_8000, 32'h0017_0000, AluopSll,  AluselShift, 0);
        add(32'hffff_8000, 32'h0017_8000, AluopSrl,  AluselShift, 0);
        add(32'hffff_8000, 32'h0018_0000, AluopSra,  AluselShift, 0);
        add(32'hffff_8000, 32'h0040_8000, AluopSll,  AluselShift, 3);
        add(32'hffff_8000, 32'h0044_8000, AluopSrl,  AluselShift, 3);
        add(32'hffff_8000, 32'h0048_8000, AluopSra,  AluselShift, 3);
    endfunction

    // Value of a read source as EXE should see it: r0, youngest forward, or regfile.
    function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                    output logic [31:0] v, output logic rdy);
        v = rf;
        rdy = 1'b1;
        if (a == 5'd0) begin
            v = 0;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            if (fvalid[p] && fwaddr[p*5 +: 5] == a) begin
                v = fwdata[p*32 +: 32];
                rdy = frdy[p];
                return;
            end
        end
    endfunction

    logic        m_valid, m_wreg, m_ivalid;
    logic [7:0]  m_aop;
    logic [2:0]  m_asel;
    logic [31:0] m_r1, m_r2, m_pc;
    logic [4:0]  m_wa;
    int          m_cnt;

    task automatic model_reset();
        m_valid = 0; m_wreg = 0; m_ivalid = 0; m_aop = AluopNop; m_asel = AluselNop;
        m_r1 = 0; m_r2 = 0; m_pc = 0; m_wa = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".ex_valid"}, ex_valid, m_valid);
        check_eq({ph, ".aluop"}, aluop, m_aop);
        check_eq({ph, ".alusel"}, alusel, m_asel);
        check_eq({ph, ".reg1"}, reg1, m_r1);
        check_eq({ph, ".reg2"}, reg2, m_r2);
        check_eq({ph, ".waddr"}, waddr, m_wa);
        check_eq({ph, ".wreg"}, wreg, m_wreg);
        check_eq({ph, ".inst_valid"}, ivalid, m_ivalid);
        check_eq({ph, ".pc"}, ipc, m_pc);
        check_eq({ph, ".stall_cnt"}, scnt, m_cnt);
    endtask

    // One clock: check combinational outputs, predict, advance, compare registers.
    task automatic step();
        logic [31:0] v1, v2, imm, o1, o2;
        logic k1, k2, re1, re2, legal, hz, adv, ifr, acc;
        logic [7:0] aop;
        logic [2:0] asel;
        #1;
        legal = 0; re1 = 0; re2 = 0; imm = 0; aop = AluopNop; asel = AluselNop;
        foreach (tbl[i]) begin
            if ((inst & tbl[i].mask) == tbl[i].match) begin
                legal = 1; aop = tbl[i].aop; asel = tbl[i].asel;
                re1 = (tbl[i].kind != 4);
                re2 = (tbl[i].kind == 0);
                case (tbl[i].kind)
                    1: imm = {{20{inst[21]}}, inst[21:10]};
                    2: imm = {20'b0, inst[21:10]};
                    3: imm = {27'b0, inst[14:10]};
                    4: imm = {inst[24:5], 12'b0};
                    default: imm = 0;
                endcase
            end
        end
        resolve(inst[9:5], r1d, v1, k1);
        resolve(inst[14:10], r2d, v2, k2);
        o1 = re1 ? v1 : 32'd0;
        o2 = re2 ? v2 : imm;
        hz  = if_valid && ((re1 && !k1) || (re2 && !k2));
        adv = !m_valid || ex_ready;
        ifr = flush || (adv && !hz);
        acc = if_valid && ifr && !flush;
        check_eq("if_ready", if_ready, ifr);
        check_eq("reg1_addr", r1a, inst[9:5]);
        check_eq("reg2_addr", r2a, inst[14:10]);
        if (hz && adv && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_aop = aop; m_asel = asel; m_r1 = o1; m_r2 = o2;
            m_wa = inst[4:0]; m_wreg = legal; m_ivalid = legal; m_pc = pc;
        end else if (adv) m_valid = 0;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle_inputs();
        flush = 0; if_valid = 0; ex_ready = 1; pc = 0; inst = 0; r1d = 0; r2d = 0;
        fvalid = 0; fwaddr = 0; fwdata = 0; frdy = '1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] p);
        if_valid = 1; inst = i; pc = p;
    endtask

    initial begin
        build_table();
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 0;

        // ORI r1,r0,0x123
        present(32'h0384_8c01, 32'h100);
        r1d = 32'hdead_beef;
        step();
        check_eq("ori.ex_valid", ex_valid, 1);
        check_eq("ori.reg1", reg1, 0);
        check_eq("ori.reg2", reg2, 32'h123);
        check_eq("ori.waddr", waddr, 1);
        check_eq("ori.wreg", wreg, 1);

        // ADDI.W r2,r1,-1 with r1=5
        present(32'h02bf_fc22, 32'h104);
        r1d = 5;
        step();
        check_eq("addi.reg1", reg1, 5);
        check_eq("addi.reg2", reg2, 32'hffff_ffff);

        // ADD.W r3,r1,r2: both ports hit r1, port 0 wins
        present(32'h0010_0823, 32'h108);
        fvalid = 2'b11; fwaddr = {5'd1, 5'd1}; fwdata = {32'hbbbb, 32'haaaa}; frdy = 2'b11;
        step();
        check_eq("prio.reg1", reg1, 32'haaaa);

        // Load-use on port 0 for three cycles
        fvalid = 2'b01; fwaddr = {5'd0, 5'd1}; frdy = 2'b00; fwdata = 0;
        present(32'h0010_0823, 32'h10c);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("lu.bubble", ex_valid, 0);
        end
        check_eq("lu.stall_cnt", scnt, 3);
        frdy = 2'b01; fwdata = {32'h0, 32'h55};
        step();
        check_eq("lu.accept", ex_valid, 1);
        check_eq("lu.reg1", reg1, 32'h55);

        // Backpressure holds outputs
        fvalid = 0; ex_ready = 0;
        present(32'h0384_8c01, 32'h110);
        repeat (2) begin
            step();
            check_eq("bp.reg1", reg1, 32'h55);
            check_eq("bp.pc", ipc, 32'h10c);
        end

        // Flush drops the held instruction and the presented one
        flush = 1;
        step();
        check_eq("flush.ex_valid", ex_valid, 0);
        flush = 0; ex_ready = 1;

        // Illegal word advances as a non-writing, invalid instruction
        present(32'hffff_ffff, 32'h114);
        step();
        check_eq("ill.ex_valid", ex_valid, 1);
        check_eq("ill.inst_valid", ivalid, 0);
        check_eq("ill.wreg", wreg, 0);

        // Reset asserted in the middle of a stall
        present(32'h0010_0823, 32'h118);
        fvalid = 2'b01; fwaddr = {5'd0, 5'd1}; frdy = 2'b00;
        step();
        #2 rst = 1;
        #1;
        model_reset();
        check_outputs("rst_mid");
        #1 rst = 0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int k;
            logic [31:0] w;
            k = $urandom_range(0, tbl.size() - 1);
            w = tbl[k].match | ($urandom() & ~tbl[k].mask);
            w[4:0]   = 5'($urandom_range(0, 3));
            w[9:5]   = 5'($urandom_range(0, 3));
            w[14:10] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) w = $urandom();
            inst     = w;
            pc       = $urandom();
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            r1d      = $urandom();
            r2d      = $urandom();
            fvalid   = NP'($urandom());
            fwaddr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwdata   = {$urandom(), $urandom()};
            frdy     = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
